alu_datapath: RTL

Execution datapath driven by the lab sequencing controller: consumes its per-cycle control word (CLR, W, CE, SEL, S) and performs operand loads, ALU operations, accumulation and output capture on two external operands. Sits directly below the controller in the lab top level; controller outputs connect 1:1 to this block's control inputs. Reports a registered result, a result-valid indication and ALU status flags.

---
 rtl/alu_dp_pkg.sv | 33 +++
 rtl/dp_alu.sv | 52 +++++
 rtl/alu_datapath.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_dp_pkg.sv
// Shared constants for the lab execution datapath: ALU opcodes, output-mux
// selects, operand-select bits, load-enable indices and flag bit positions.
package alu_dp_pkg;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    localparam logic [2:0] W_ZERO  = 3'd0;
    localparam logic [2:0] W_RA    = 3'd1;
    localparam logic [2:0] W_RB    = 3'd2;
    localparam logic [2:0] W_ALU   = 3'd3;
    localparam logic [2:0] W_ACC   = 3'd4;
    localparam logic [2:0] W_FLAGS = 3'd5;

    localparam int SEL_X_ACC = 0;
    localparam int SEL_Y_RA  = 1;

    localparam int CE_RA  = 0;
    localparam int CE_RB  = 1;
    localparam int CE_OUT = 2;
    localparam int CE_ACC = 3;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for alu_datapath: truncated result plus carry, borrow
// or shifted-out bit depending on the opcode.
module dp_alu
    import alu_dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] wide_s;

    // Opcode decode; add/sub run one bit wide so the top bit is carry/borrow
    always_comb begin
        wide_s = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_PASS: result = x;
            OP_ADD: begin
                wide_s = {1'b0, x} + {1'b0, y};
                result = wide_s[WIDTH-1:0];
                carry  = wide_s[WIDTH];
            end
            OP_SUB: begin
                wide_s = {1'b0, x} - {1'b0, y};
                result = wide_s[WIDTH-1:0];
                carry  = wide_s[WIDTH];
            end
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            OP_XOR:  result = x ^ y;
            OP_SHL: begin
                result = {x[WIDTH-2:0], 1'b0};
                carry  = x[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, x[WIDTH-1:1]};
                carry  = x[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// Execution datapath below the lab sequencing controller: operand, accumulator
// and output registers around dp_alu. Flag logic is built only with ALU_DATAPATH_FLAGS_EN.
module alu_datapath
    import alu_dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic [3:0]       CE,
    input  logic [1:0]       SEL,
    input  logic [2:0]       S,
    input  logic [2:0]       W,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             VALID,
    output logic [2:0]       FLAGS
);

    logic [WIDTH-1:0] ra_r;
    logic [WIDTH-1:0] rb_r;
    logic [WIDTH-1:0] racc_r;
    logic [WIDTH-1:0] rout_r;
    logic             valid_r;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [WIDTH-1:0] wmux_s;

`ifdef ALU_DATAPATH_FLAGS_EN
    logic             alu_carry_s;
    logic [2:0]       flags_r;
    logic [2:0]       flags_next_s;
`else
    logic             carry_unused_s;
`endif

    // ALU operand steering
    always_comb begin
        if (SEL[SEL_X_ACC]) begin
            x_s = racc_r;
        end else begin
            x_s = ra_r;
        end
        if (SEL[SEL_Y_RA]) begin
            y_s = ra_r;
        end else begin
            y_s = rb_r;
        end
    end

    dp_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x      (x_s),
        .y      (y_s),
        .op     (S),
`ifdef ALU_DATAPATH_FLAGS_EN
        .carry  (alu_carry_s),
`else
        .carry  (carry_unused_s),
`endif
        .result (alu_res_s)
    );

`ifdef ALU_DATAPATH_FLAGS_EN
    // Flags describe the value RACC is about to take
    always_comb begin
        flags_next_s         = 3'b000;
        flags_next_s[FLAG_N] = alu_res_s[WIDTH-1];
        flags_next_s[FLAG_Z] = (alu_res_s == '0);
        flags_next_s[FLAG_C] = alu_carry_s;
    end
`endif

    // Output-mux source for the ROUT load
    always_comb begin
        wmux_s = '0;
        case (W)
            W_ZERO:  wmux_s = '0;
            W_RA:    wmux_s = ra_r;
            W_RB:    wmux_s = rb_r;
            W_ALU:   wmux_s = alu_res_s;
            W_ACC:   wmux_s = racc_r;
`ifdef ALU_DATAPATH_FLAGS_EN
            W_FLAGS: wmux_s = WIDTH'(flags_r);
`else
            W_FLAGS: wmux_s = '0;
`endif
            default: wmux_s = '0;
        endcase
    end

    // Register file: all enables sample pre-edge values; CLR beats every load
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ra_r    <= '0;
            rb_r    <= '0;
            racc_r  <= '0;
            rout_r  <= '0;
            valid_r <= 1'b0;
        end else if (CLR) begin
            ra_r    <= '0;
            rb_r    <= '0;
            racc_r  <= '0;
            rout_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            if (CE[CE_RA])  ra_r   <= A;
            if (CE[CE_RB])  rb_r   <= B;
            if (CE[CE_OUT]) rout_r <= wmux_s;
            if (CE[CE_ACC]) racc_r <= alu_res_s;
            valid_r <= CE[CE_OUT];
        end
    end

`ifdef ALU_DATAPATH_FLAGS_EN
    // Flag register follows RACC loads only
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags_r <= 3'b000;
        end else if (CLR) begin
            flags_r <= 3'b000;
        end else if (CE[CE_ACC]) begin
            flags_r <= flags_next_s;
        end
    end

    assign FLAGS = flags_r;
`else
    assign FLAGS = 3'b000;
`endif

    assign Y     = rout_r;
    assign VALID = valid_r;

endmodule
